dma_bus_arbiter: RTL
====================

DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of bus masters (2..8).
REQ-002 SHALL have parameter BEGIN_WINDOW, default 2, cycles after grant in which begin_transaction must appear.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit for an open transaction.
REQ-004 SHALL have ports: clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-high.
REQ-006 SHALL have ports: request  in  NUM_MASTERS  per-master bus request, level.
REQ-007 SHALL have ports: grants  out  NUM_MASTERS  one-hot grant, registered.
REQ-008 SHALL have ports: busIn_begin_transaction, busIn_end_transaction, busIn_error  in  1 each  shared-bus monitor.
REQ-009 SHALL have ports: busOut_end_transaction, busOut_error  out  1 each  arbiter-forced abort.
REQ-010 SHALL have ports: active_master  out  $clog2(NUM_MASTERS)  owner index; bus_idle  out  1  high in IDLE.

Function
REQ-011 SHALL implement states IDLE, GRANT, WAIT_BEGIN, BUSY, ABORT.
REQ-012 IDLE: any request bit high -> GRANT next cycle; no requests -> stay.
REQ-013 Winner SHALL be the first requesting index after rr_pointer, wrapping modulo NUM_MASTERS.
REQ-014 GRANT SHALL last exactly one cycle with grants = one-hot winner; all other states drive grants = 0.
REQ-015 Latency: request high at edge N (IDLE) -> grant high in cycle N+1 -> WAIT_BEGIN at N+2.
REQ-016 WAIT_BEGIN: begin_transaction -> BUSY; BEGIN_WINDOW cycles without it -> IDLE, rr_pointer still advances to winner.
REQ-017 BUSY: busIn_end_transaction -> IDLE; rr_pointer <= active_master.
REQ-018 busIn_error in WAIT_BEGIN or BUSY SHALL force IDLE on the next edge; rr_pointer advances.
REQ-019 Begin and end in the same cycle in WAIT_BEGIN SHALL go to IDLE (single-word transaction).
REQ-020 active_master SHALL hold the winner from GRANT until return to IDLE; 0 in IDLE.
REQ-021 Request withdrawal after grant SHALL be ignored; only bus monitor signals close a tenure.
REQ-022 Counters SHALL saturate, never wrap; watchdog width $clog2(TIMEOUT_CYCLES+1).

Reset
REQ-023 Reset assertion SHALL immediately force IDLE, grants = 0, active_master = 0, bus_idle = 1, busOut_* = 0.
REQ-024 Reset SHALL set rr_pointer = NUM_MASTERS-1, giving master 0 first priority.
REQ-025 Reset mid-tenure SHALL drop grant ownership without issuing busOut_end_transaction.

Configuration
REQ-026 Macro DMA_BUS_ARBITER_WATCHDOG_EN defined: BUSY counts cycles; at TIMEOUT_CYCLES without end -> ABORT.
REQ-027 ABORT SHALL last one cycle asserting busOut_end_transaction = 1 and busOut_error = 1, then IDLE with rr_pointer advanced.
REQ-028 Macro undefined: no watchdog counter, ABORT unreachable, busOut_end_transaction and busOut_error tied 0, BUSY waits indefinitely.

Structure
REQ-029 Package dma_bus_pkg SHALL hold the state enum and default constants (BEGIN_WINDOW, TIMEOUT_CYCLES).
REQ-030 Winner selection SHALL live in combinational sub-module rr_priority_picker (request, rr_pointer -> one-hot, index, valid).

Verification
REQ-031 Reset, request=4'b0001 -> grants=4'b0001 one cycle, begin next cycle, end 5 cycles later -> bus_idle=1, rr_pointer=0.
REQ-032 request=4'b1011 held, each tenure closed by end -> grant order 0,1,3,0,1.
REQ-033 Grant to master 2, no begin for 2 cycles -> IDLE; next grant from request=4'b0101 goes to 0.
REQ-034 BUSY with busIn_error=1 at cycle 7 -> IDLE next edge, no busOut_error, rr_pointer advanced.
REQ-035 WATCHDOG_EN, TIMEOUT_CYCLES=16, no end -> busOut_end_transaction=busOut_error=1 for exactly one cycle at BUSY+16.
REQ-036 Reset pulsed mid-BUSY (async, between edges) -> grants=0, bus_idle=1 immediately; master 0 wins next.

Source files
------------

// File: rtl/dma_bus_pkg.sv
// Shared types and default constants for the DMA bus arbiter.
package dma_bus_pkg;

  localparam int unsigned DEFAULT_NUM_MASTERS    = 4;
  localparam int unsigned DEFAULT_BEGIN_WINDOW   = 2;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GRANT      = 3'd1,
    ST_WAIT_BEGIN = 3'd2,
    ST_BUSY       = 3'd3,
    ST_ABORT      = 3'd4
  } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin winner selection: first requesting index after rr_pointer, wrapping.
module rr_priority_picker #(
  parameter int unsigned NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0]         request,
  input  logic [$clog2(NUM_MASTERS)-1:0] rr_pointer,
  output logic [NUM_MASTERS-1:0]         onehot,
  output logic [$clog2(NUM_MASTERS)-1:0] index,
  output logic                           valid
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int off = int'(NUM_MASTERS); off > 0; off--) begin
      cand = IDX_W'((int'(rr_pointer) + off) % int'(NUM_MASTERS));
      if (request[cand]) begin
        index = cand;
        valid = 1'b1;
      end
    end
    if (valid) begin
      onehot = NUM_MASTERS'(1) << index;
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Round-robin shared-bus arbiter with begin window and optional BUSY watchdog.
// Watchdog/abort path enabled by defining DMA_BUS_ARBITER_WATCHDOG_EN.
module dma_bus_arbiter
  import dma_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = DEFAULT_NUM_MASTERS,
  parameter int unsigned BEGIN_WINDOW   = DEFAULT_BEGIN_WINDOW,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         request,
  output logic [NUM_MASTERS-1:0]         grants,
  input  logic                           busIn_begin_transaction,
  input  logic                           busIn_end_transaction,
  input  logic                           busIn_error,
  output logic                           busOut_end_transaction,
  output logic                           busOut_error,
  output logic [$clog2(NUM_MASTERS)-1:0] active_master,
  output logic                           bus_idle
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned WIN_W = $clog2(BEGIN_WINDOW + 1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || BEGIN_WINDOW < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("dma_bus_arbiter: unsupported parameter combination");
  end

  state_t           state;
  logic [IDX_W-1:0] rr_pointer;
  logic [WIN_W-1:0] win_cnt;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_index;
  logic                   pick_valid;

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .request    (request),
    .rr_pointer (rr_pointer),
    .onehot     (pick_onehot),
    .index      (pick_index),
    .valid      (pick_valid)
  );

`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign busOut_end_transaction = 1'b0;
  assign busOut_error           = 1'b0;
`endif

  // Every return to IDLE releases ownership and moves rr_pointer to the last owner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      grants        <= '0;
      active_master <= '0;
      bus_idle      <= 1'b1;
      rr_pointer    <= IDX_W'(NUM_MASTERS - 1);
      win_cnt       <= '0;
`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
      wd_cnt                 <= '0;
      busOut_end_transaction <= 1'b0;
      busOut_error           <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state         <= ST_GRANT;
            grants        <= pick_onehot;
            active_master <= pick_index;
            bus_idle      <= 1'b0;
          end
        end
        ST_GRANT: begin
          state   <= ST_WAIT_BEGIN;
          grants  <= '0;
          win_cnt <= '0;
        end
        ST_WAIT_BEGIN: begin
          if (busIn_error || (busIn_begin_transaction && busIn_end_transaction)) begin
            state         <= ST_IDLE;
            active_master <= '0;
            bus_idle      <= 1'b1;
            rr_pointer    <= active_master;
          end else if (busIn_begin_transaction) begin
            state <= ST_BUSY;
`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
            wd_cnt <= '0;
`endif
          end else if (win_cnt >= WIN_W'(BEGIN_WINDOW - 1)) begin
            state         <= ST_IDLE;
            active_master <= '0;
            bus_idle      <= 1'b1;
            rr_pointer    <= active_master;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        ST_BUSY: begin
          if (busIn_error || busIn_end_transaction) begin
            state         <= ST_IDLE;
            active_master <= '0;
            bus_idle      <= 1'b1;
            rr_pointer    <= active_master;
          end
`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
          else if (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1)) begin
            state                  <= ST_ABORT;
            busOut_end_transaction <= 1'b1;
            busOut_error           <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        ST_ABORT: begin
          state         <= ST_IDLE;
          active_master <= '0;
          bus_idle      <= 1'b1;
          rr_pointer    <= active_master;
`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
          busOut_end_transaction <= 1'b0;
          busOut_error           <= 1'b0;
`endif
        end
        default: begin
          state         <= ST_IDLE;
          grants        <= '0;
          active_master <= '0;
          bus_idle      <= 1'b1;
        end
      endcase
    end
  end

endmodule
